// File: rtl/bip_ctrl_pkg.sv
// Shared constants for the BIP run/debug controller: host command bytes,
// default report headers, controller state encoding and report frame length.
package bip_ctrl_pkg;

  // Host command bytes (ASCII)
  localparam logic [7:0] CMD_CLEAR = 8'h43;  // 'C'
  localparam logic [7:0] CMD_RUN   = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_QUERY = 8'h51;  // 'Q'

  // Report frame headers
  localparam logic [7:0] HDR_OK_DEF = 8'hA5;
  localparam logic [7:0] HDR_TO_DEF = 8'hEE;

  // Controller states; the frame transmitter reuses IDLE/TX_REQ/TX_WAIT
  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_CLEAR   = 3'd1;
  localparam logic [ST_W-1:0] ST_RUN     = 3'd2;
  localparam logic [ST_W-1:0] ST_STEP    = 3'd3;
  localparam logic [ST_W-1:0] ST_SNAP    = 3'd4;
  localparam logic [ST_W-1:0] ST_TX_REQ  = 3'd5;
  localparam logic [ST_W-1:0] ST_TX_WAIT = 3'd6;

  // Frame = header + accumulator bytes + instruction count byte
  function automatic int unsigned frame_len(input int unsigned acc_w);
    return 2 + acc_w / 8;
  endfunction

endpackage

// File: rtl/bip_frame_tx.sv
// Report frame transmitter: snapshots header/accumulator/count on load_i and
// sends them byte by byte (header, accumulator MSB first, count) via a
// start/busy handshake with the UART TX serializer.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   load_i          1-cycle strobe: latch snapshot and begin the frame
//   hdr_i/acc_i/cnt_i  snapshot values
//   tx_busy_i       serializer busy
//   tx_data_o       byte being sent, stable until the serializer finishes it
//   tx_start_o      request, held until tx_busy_i is seen high
//   frame_done_o    1-cycle pulse after the last byte completes
module bip_frame_tx
  import bip_ctrl_pkg::*;
#(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [7:0]       hdr_i,
  input  logic [ACC_W-1:0] acc_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             tx_busy_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_start_o,
  output logic             frame_done_o
);

  localparam int unsigned FRAME_LEN = frame_len(ACC_W);
  localparam int unsigned FRAME_W   = ACC_W + CNT_W + 8;
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);

  logic [ST_W-1:0]    phase_q, phase_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FRAME_W-1:0] sr_q, sr_d;      // bytes still to send, top-aligned
  logic [7:0]         data_q, data_d;
  logic               start_q, start_d;
  logic               done_q, done_d;

  // Handshake sequencing; a load always restarts the frame from the header
  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    data_d  = data_q;
    start_d = start_q;
    done_d  = 1'b0;
    case (phase_q)
      ST_TX_REQ: begin
        // busy high is the handoff, even if it was already high on entry
        if (tx_busy_i) begin
          start_d = 1'b0;
          phase_d = ST_TX_WAIT;
        end
      end
      ST_TX_WAIT: begin
        if (!tx_busy_i) begin
          if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
            phase_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            data_d  = sr_q[FRAME_W-1 -: 8];
            sr_d    = sr_q << 8;
            start_d = 1'b1;
            phase_d = ST_TX_REQ;
          end
        end
      end
      default: ;
    endcase
    if (load_i) begin
      phase_d = ST_TX_REQ;
      idx_d   = '0;
      data_d  = hdr_i;
      sr_d    = {acc_i, cnt_i, 8'h00};
      start_d = 1'b1;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= ST_IDLE;
      idx_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  assign tx_data_o    = data_q;
  assign tx_start_o   = start_q;
  assign frame_done_o = done_q;

endmodule

// File: rtl/bip_run_ctrl.sv
// Run/debug controller between UART RX, the BIP core and UART TX. Decodes
// single-byte host commands (C clear, R run, S step, Q query), gates BIP
// execution through a clock enable, snapshots accumulator and instruction
// count, and reports them as a frame through bip_frame_tx.
// Optional build macro BIP_RUN_CTRL_WATCHDOG_EN: aborts a run after MAX_RUN
// enabled cycles without done and reports with header HDR_TO.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   i_rx_data/i_rx_valid  command byte and its 1-cycle strobe
//   i_bip_done            BIP halted (level)
//   i_accumulator         BIP accumulator
//   i_inst_count          BIP instruction count
//   o_bip_en              BIP clock enable (gated combinationally by done)
//   o_bip_clr             1-cycle clear pulse to the BIP
//   o_tx_data/o_tx_start  report byte and TX request
//   i_tx_busy             TX serializer busy
//   o_busy                controller not idle
//   o_cmd_err             1-cycle pulse: command dropped
module bip_run_ctrl
  import bip_ctrl_pkg::*;
#(
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned CNT_W   = 8,
`ifdef BIP_RUN_CTRL_WATCHDOG_EN
  parameter logic [7:0]  HDR_TO  = HDR_TO_DEF,
  parameter int unsigned MAX_RUN = 4096,
`endif
  parameter logic [7:0]  HDR_OK  = HDR_OK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  input  logic             i_bip_done,
  input  logic [ACC_W-1:0] i_accumulator,
  input  logic [CNT_W-1:0] i_inst_count,
  output logic             o_bip_en,
  output logic             o_bip_clr,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_start,
  input  logic             i_tx_busy,
  output logic             o_busy,
  output logic             o_cmd_err
);

  logic [ST_W-1:0] state_q, state_d;
  logic            err_q, err_d;
  logic            load_c;
  logic            frame_done;
  logic [7:0]      hdr_c;

`ifdef BIP_RUN_CTRL_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(MAX_RUN + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;
`endif

  // Command decode and run sequencing
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    load_c  = 1'b0;
`ifdef BIP_RUN_CTRL_WATCHDOG_EN
    wd_d    = wd_q;
    to_d    = to_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
`ifdef BIP_RUN_CTRL_WATCHDOG_EN
          to_d = 1'b0;
`endif
          case (i_rx_data)
            CMD_CLEAR: state_d = ST_CLEAR;
            CMD_RUN: begin
              state_d = ST_RUN;
`ifdef BIP_RUN_CTRL_WATCHDOG_EN
              wd_d    = '0;
`endif
            end
            CMD_STEP:  state_d = ST_STEP;
            CMD_QUERY: state_d = ST_SNAP;
            default:   err_d   = 1'b1;
          endcase
        end
      end
      ST_CLEAR: state_d = ST_IDLE;
      ST_RUN: begin
        if (i_bip_done) begin
          state_d = ST_SNAP;
        end
`ifdef BIP_RUN_CTRL_WATCHDOG_EN
        else begin
          // this cycle is enabled; leave once it is the MAX_RUN-th one
          wd_d = wd_q + WD_W'(1);
          if (wd_q == WD_W'(MAX_RUN - 1)) begin
            state_d = ST_SNAP;
            to_d    = 1'b1;
          end
        end
`endif
      end
      ST_STEP: state_d = ST_SNAP;
      ST_SNAP: begin
        load_c  = 1'b1;
        state_d = ST_TX_REQ;
      end
      ST_TX_REQ: begin
        if (frame_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_rx_valid && (state_q != ST_IDLE)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

`ifdef BIP_RUN_CTRL_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end

  assign hdr_c = to_q ? HDR_TO : HDR_OK;
`else
  assign hdr_c = HDR_OK;
`endif

  // Enable drops in the same cycle done rises
  assign o_bip_en  = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !i_bip_done;
  assign o_bip_clr = (state_q == ST_CLEAR);
  assign o_busy    = (state_q != ST_IDLE);
  assign o_cmd_err = err_q;

  bip_frame_tx #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_frame_tx (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load_c),
    .hdr_i        (hdr_c),
    .acc_i        (i_accumulator),
    .cnt_i        (i_inst_count),
    .tx_busy_i    (i_tx_busy),
    .tx_data_o    (o_tx_data),
    .tx_start_o   (o_tx_start),
    .frame_done_o (frame_done)
  );

endmodule

// File: tb/tb_bip_run_ctrl.sv
// Bench for bip_run_ctrl: a behavioural BIP stub and TX serializer stub
// surround the controller; each command's expected enable count, clear
// pulses and report frame come from an arithmetic model of the command rules.
module tb_bip_run_ctrl;

  localparam int unsigned ACC_W = 16;
  localparam int unsigned CNT_W = 8;
`ifdef BIP_RUN_CTRL_WATCHDOG_EN
  localparam int unsigned MAX_RUN = 16;
`endif

  logic             clk;
  logic             rst;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             bip_done;
  logic [ACC_W-1:0] bip_acc;
  logic [CNT_W-1:0] bip_cnt;
  logic             o_bip_en, o_bip_clr, o_tx_start, o_busy, o_cmd_err;
  logic [7:0]       o_tx_data;
  logic             tx_busy = 1'b0;

  bip_run_ctrl #(
`ifdef BIP_RUN_CTRL_WATCHDOG_EN
    .MAX_RUN (MAX_RUN),
`endif
    .ACC_W   (ACC_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_rx_data     (rx_data),
    .i_rx_valid    (rx_valid),
    .i_bip_done    (bip_done),
    .i_accumulator (bip_acc),
    .i_inst_count  (bip_cnt),
    .o_bip_en      (o_bip_en),
    .o_bip_clr     (o_bip_clr),
    .o_tx_data     (o_tx_data),
    .o_tx_start    (o_tx_start),
    .i_tx_busy     (tx_busy),
    .o_busy        (o_busy),
    .o_cmd_err     (o_cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- BIP stub: each enabled cycle executes one instruction
  logic [15:0] acc_base = 16'h0;
  logic [15:0] acc_inc  = 16'h0;
  logic [15:0] acc_run  = 16'h0;
  logic [7:0]  stub_cnt = 8'h0;
  int          halt     = 0;

  assign bip_cnt  = stub_cnt;
  assign bip_acc  = acc_base + acc_run;
  assign bip_done = (int'(stub_cnt) >= halt);

  always @(posedge clk) begin
    if (o_bip_clr) begin
      acc_run  <= 16'h0;
      stub_cnt <= 8'h0;
    end else if (o_bip_en) begin
      acc_run  <= acc_run + acc_inc;
      stub_cnt <= stub_cnt + 8'd1;
    end
  end

  // ---------------- TX serializer stub: records each byte it accepts
  logic [7:0] cap [0:1023];
  int         cap_n     = 0;
  int         busy_left = 0;

  always @(posedge clk) begin
    if (tx_busy) begin
      if (busy_left <= 1) tx_busy <= 1'b0;
      busy_left <= busy_left - 1;
    end else if (o_tx_start) begin
      cap[cap_n] <= o_tx_data;
      cap_n      <= cap_n + 1;
      tx_busy    <= 1'b1;
      busy_left  <= int'($urandom_range(1, 4));
    end
  end

  // ---------------- Monitors
  int en_total  = 0;
  int clr_total = 0;
  int inv_err   = 0;
  int stab_err  = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (o_bip_en)  en_total  = en_total + 1;
      if (o_bip_clr) clr_total = clr_total + 1;
      if ((o_bip_en && o_bip_clr) || (o_bip_en && !o_busy)) inv_err = inv_err + 1;
      if (tx_busy && o_busy && (cap_n > 0) && (o_tx_data != cap[cap_n-1]))
        stab_err = stab_err + 1;
    end
  end

  // ---------------- Checking
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- Reference model of the BIP as seen through the controller
  logic [7:0]  m_cnt = 8'h0;
  logic [15:0] m_run = 16'h0;

  function automatic bit is_cmd(input logic [7:0] b);
    return (b == 8'h43) || (b == 8'h52) || (b == 8'h53) || (b == 8'h51);
  endfunction

  task automatic send(input logic [7:0] b, input logic exp_err);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk($sformatf("cmd_err_%02h", b), 32'(o_cmd_err), 32'(exp_err));
  endtask

  task automatic wait_idle();
    int k = 0;
    while (o_busy && (k < 4000)) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 32'(o_busy), 32'd0);
  endtask

  task automatic check_frame(input int cap0, input logic [31:0] f);
    chk("frame_len", 32'(cap_n - cap0), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("frame_byte%0d", i), 32'(cap[cap0 + i]), 32'(f[31 - 8*i -: 8]));
  endtask

  function automatic logic [31:0] exp_frame(input logic [7:0] hdr);
    logic [15:0] a;
    a = acc_base + m_run;
    return {hdr, a, m_cnt};
  endfunction

  // One command in IDLE, predicted from the command rules and checked
  task automatic do_cmd(input logic [7:0] b);
    int         en0, clr0, cap0, n, rem;
    logic [7:0] hdr;
    bit         frame;
    en0 = en_total; clr0 = clr_total; cap0 = cap_n;
    n = 0; hdr = 8'hA5; frame = 1'b1;
    case (b)
      8'h43: begin frame = 1'b0; m_cnt = 8'h0; m_run = 16'h0; end
      8'h52: begin
        rem = halt - int'(m_cnt);
        n   = (rem > 0) ? rem : 0;
`ifdef BIP_RUN_CTRL_WATCHDOG_EN
        if (n >= int'(MAX_RUN)) begin n = int'(MAX_RUN); hdr = 8'hEE; end
`endif
      end
      8'h53: n = (int'(m_cnt) < halt) ? 1 : 0;
      8'h51: n = 0;
      default: frame = 1'b0;
    endcase
    m_cnt = m_cnt + 8'(n);
    m_run = m_run + 16'(n) * acc_inc;
    send(b, !is_cmd(b));
    wait_idle();
    chk($sformatf("en_cycles_%02h", b), 32'(en_total - en0), 32'(n));
    chk($sformatf("clr_pulses_%02h", b), 32'(clr_total - clr0), (b == 8'h43) ? 32'd1 : 32'd0);
    if (frame) check_frame(cap0, exp_frame(hdr));
    else       chk($sformatf("no_tx_%02h", b), 32'(cap_n - cap0), 32'd0);
  endtask

  initial begin
    int         cap0, k, sel;
    logic [7:0] jb;
    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #1;
    chk("reset_outputs", 32'({o_bip_en, o_bip_clr, o_tx_start, o_busy, o_cmd_err, o_tx_data}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Clear then query: one clear pulse, no frame, then all-zero report
    halt = 0; acc_base = 16'h0; acc_inc = 16'h0;
    do_cmd(8'h43);
    do_cmd(8'h51);

    // Run to done at acc=1234, cnt=07
    acc_base = 16'h1234; acc_inc = 16'h0; halt = 7;
    do_cmd(8'h43);
    do_cmd(8'h52);

    // Three single steps from clear
    acc_base = 16'h0; acc_inc = 16'h0011; halt = 100;
    do_cmd(8'h43);
    repeat (3) do_cmd(8'h53);

    // Run when already done: no enable cycles
    halt = int'(m_cnt);
    do_cmd(8'h52);

    // Command during a frame is dropped; frame stays intact
    cap0 = cap_n;
    send(8'h51, 1'b0);
    k = 0;
    while ((cap_n == cap0) && (k < 200)) begin @(negedge clk); k++; end
    send(8'h52, 1'b1);
    wait_idle();
    check_frame(cap0, exp_frame(8'hA5));
    do_cmd(8'h00);

    // Reset in the middle of the second frame byte
    cap0 = cap_n;
    send(8'h51, 1'b0);
    k = 0;
    while ((cap_n < cap0 + 2) && (k < 200)) begin @(negedge clk); k++; end
    chk("second_byte_seen", 32'(cap_n - cap0), 32'd2);
    #2 rst = 1'b0;
    #1 chk("midframe_reset_outputs",
           32'({o_bip_en, o_bip_clr, o_tx_start, o_busy, o_cmd_err, o_tx_data}), 32'd0);
    k = 0;
    while (tx_busy && (k < 50)) begin @(negedge clk); k++; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'({o_busy, o_tx_start}), 32'd0);
    do_cmd(8'h51);

`ifdef BIP_RUN_CTRL_WATCHDOG_EN
    // Program that never halts: watchdog stops it after MAX_RUN enables
    acc_inc = 16'h0101; halt = 1000000;
    do_cmd(8'h43);
    do_cmd(8'h52);
    do_cmd(8'h51);
    halt = 0;
`endif

    // Randomized command mix
    do_cmd(8'h43);
    for (int it = 0; it < 24; it++) begin
      acc_inc = 16'($urandom);
      halt    = int'(m_cnt) + int'($urandom_range(0, 6)) - 1;
      sel     = int'($urandom_range(0, 9));
      if (sel == 0)      do_cmd(8'h43);
      else if (sel <= 3) do_cmd(8'h52);
      else if (sel <= 6) do_cmd(8'h53);
      else if (sel <= 8) do_cmd(8'h51);
      else begin
        jb = 8'($urandom);
        while (is_cmd(jb)) jb = 8'($urandom);
        do_cmd(jb);
      end
    end

    chk("en_clr_invariant", 32'(inv_err), 32'd0);
    chk("tx_data_stable", 32'(stab_err), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
